// File: rtl/shifter_pkg.sv
// shifter_pkg: shared encodings and helpers for pipelined_shifter.
package shifter_pkg;
    localparam logic DIR_LEFT   = 1'b0;
    localparam logic DIR_RIGHT  = 1'b1;
    localparam logic MODE_LOGIC = 1'b0;
    localparam logic MODE_ARITH = 1'b1;
    localparam int   MAX_XLEN   = 128;

    function automatic int calc_nstages(input int xlen, input int levels);
        return ($clog2(xlen) + levels - 1) / levels;
    endfunction

    function automatic logic [MAX_XLEN-1:0] bit_rev(input logic [MAX_XLEN-1:0] v);
        return {<<{v}};
    endfunction
endpackage

// File: rtl/shift_stage.sv
// shift_stage: NLEVELS right-shift mux levels plus one handshaked pipeline register.
module shift_stage #(
    parameter int XLEN        = 64,
    parameter int TAG_W       = 5,
    parameter int FIRST_LEVEL = 5,
    parameter int NLEVELS     = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic                     i_next_ready,
    output logic                     o_valid,
    input  logic [XLEN-1:0]          i_data,
    input  logic                     i_fill,
    input  logic [$clog2(XLEN)-1:0]  i_shamt,
    input  logic [TAG_W-1:0]         i_tag,
    output logic [XLEN-1:0]          o_data,
    output logic                     o_fill,
    output logic [$clog2(XLEN)-1:0]  o_shamt,
    output logic [TAG_W-1:0]         o_tag
);
    localparam int L = $clog2(XLEN);

    logic [XLEN-1:0]  w_lvl [NLEVELS+1];
    logic             r_valid;
    logic [XLEN-1:0]  r_data;
    logic             r_fill;
    logic [L-1:0]     r_shamt;
    logic [TAG_W-1:0] r_tag;

    assign w_lvl[0] = i_data;
    for (genvar k = 0; k < NLEVELS; k++) begin : g_lvl
        localparam int SH = 2 ** (FIRST_LEVEL - k);
        assign w_lvl[k+1] = i_shamt[FIRST_LEVEL-k] ? {{SH{i_fill}}, w_lvl[k][XLEN-1:SH]} : w_lvl[k];
    end

    assign o_ready = !r_valid | i_next_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_fill  <= 1'b0;
            r_shamt <= '0;
            r_tag   <= '0;
        end else begin
            if (flush)
                r_valid <= 1'b0;
            else if (o_ready)
                r_valid <= i_valid;
            if (o_ready & i_valid & !flush) begin
                r_data  <= w_lvl[NLEVELS];
                r_fill  <= i_fill;
                r_shamt <= i_shamt;
                r_tag   <= i_tag;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_fill  = r_fill;
    assign o_shamt = r_shamt;
    assign o_tag   = r_tag;
endmodule

// File: rtl/pipelined_shifter.sv
// pipelined_shifter: RV64 SLL/SRL/SRA(+W) barrel shifter split into handshaked stages.
module pipelined_shifter
    import shifter_pkg::*;
#(
    parameter int XLEN             = 64,
    parameter int LEVELS_PER_STAGE = 2,
    parameter int TAG_W            = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [XLEN-1:0]         in_data,
    input  logic [$clog2(XLEN)-1:0] in_shamt,
    input  logic                    in_right,
    input  logic                    in_arith,
    input  logic                    in_word,
    input  logic [TAG_W-1:0]        in_tag,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [XLEN-1:0]         out_data,
    output logic [TAG_W-1:0]        out_tag
);
    localparam int L       = $clog2(XLEN);
    localparam int NSTAGES = calc_nstages(XLEN, LEVELS_PER_STAGE);
    localparam int TW      = TAG_W + 2;

    logic [XLEN-1:0] w_op, w_wext, w_res, w_res_ext;
    logic [XLEN-1:0] w_data  [NSTAGES+1];
    logic            w_fill  [NSTAGES+1];
    logic [L-1:0]    w_sh    [NSTAGES+1];
    logic [TW-1:0]   w_tag   [NSTAGES+1];
    logic            w_valid [NSTAGES+1];
    logic            w_rdy   [NSTAGES+1];
    logic            w_right, w_word, w_unused;

    if (XLEN > 32) begin : g_word
        assign w_wext    = {{(XLEN-32){in_arith & in_right & in_data[31]}}, in_data[31:0]};
        assign w_res_ext = {{(XLEN-32){w_res[31]}}, w_res[31:0]};
    end else begin : g_noword
        assign w_wext    = in_data;
        assign w_res_ext = w_res;
    end

    // Left shifts reuse the right-shift datapath by reversing bits on entry and exit.
    assign w_op       = in_word ? w_wext : in_data;
    assign w_data[0]  = (in_right == DIR_LEFT) ? XLEN'(bit_rev(MAX_XLEN'(w_op)) >> (MAX_XLEN - XLEN)) : w_op;
    assign w_fill[0]  = (in_arith == MODE_ARITH) & (in_right == DIR_RIGHT) & w_op[XLEN-1];
    assign w_sh[0]    = in_shamt & (in_word ? L'(31) : {L{1'b1}});
    assign w_tag[0]   = {in_right, in_word, in_tag};
    assign w_valid[0] = in_valid;
    assign w_rdy[NSTAGES] = out_ready;

    for (genvar s = 0; s < NSTAGES; s++) begin : g_stage
        localparam int FIRST = L - 1 - s * LEVELS_PER_STAGE;
        localparam int NL    = (FIRST + 1 < LEVELS_PER_STAGE) ? FIRST + 1 : LEVELS_PER_STAGE;
        shift_stage #(.XLEN(XLEN), .TAG_W(TW), .FIRST_LEVEL(FIRST), .NLEVELS(NL)) u_stage (
            .clk          (clk),
            .rst_n        (rst_n),
            .flush        (flush),
            .i_valid      (w_valid[s]),
            .o_ready      (w_rdy[s]),
            .i_next_ready (w_rdy[s+1]),
            .o_valid      (w_valid[s+1]),
            .i_data       (w_data[s]),
            .i_fill       (w_fill[s]),
            .i_shamt      (w_sh[s]),
            .i_tag        (w_tag[s]),
            .o_data       (w_data[s+1]),
            .o_fill       (w_fill[s+1]),
            .o_shamt      (w_sh[s+1]),
            .o_tag        (w_tag[s+1])
        );
    end

    assign {w_right, w_word, out_tag} = w_tag[NSTAGES];
    assign w_res     = (w_right == DIR_RIGHT) ? w_data[NSTAGES]
                     : XLEN'(bit_rev(MAX_XLEN'(w_data[NSTAGES])) >> (MAX_XLEN - XLEN));
    assign out_data  = w_word ? w_res_ext : w_res;
    assign out_valid = w_valid[NSTAGES] & !flush;
    assign in_ready  = w_rdy[0] & !flush;
    assign w_unused  = w_fill[NSTAGES] ^ (^w_sh[NSTAGES]);
endmodule

// File: tb/tb_pipelined_shifter.sv
// tb_pipelined_shifter: scoreboard bench for pipelined_shifter (XLEN=64, 3 stages).
module tb_pipelined_shifter;
    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, in_right, in_arith, in_word;
    logic        out_valid, out_ready;
    logic [63:0] in_data, out_data, cur_exp;
    logic [5:0]  in_shamt;
    logic [4:0]  in_tag, out_tag;
    int          n_chk = 0, n_err = 0, cyc = 0;
    bit          lat_en, rnd_done;

    typedef struct {logic [63:0] d; logic [4:0] t; int c; bit l;} exp_t;
    exp_t q[$];

    pipelined_shifter dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_shamt(in_shamt), .in_right(in_right), .in_arith(in_arith),
        .in_word(in_word), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_tag(out_tag)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [63:0] d, input logic [5:0] sh, input logic r, a, w);
        logic [31:0] x;
        if (w) begin
            if (!r) x = d[31:0] << sh[4:0];
            else if (a) x = $signed(d[31:0]) >>> sh[4:0];
            else x = d[31:0] >> sh[4:0];
            return {{32{x[31]}}, x};
        end
        if (!r) return d << sh;
        if (a) return $signed(d) >>> sh;
        return d >> sh;
    endfunction

    // Scoreboard: push on accept, compare front while valid (covers stall stability), pop on delivery.
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready) q.push_back('{cur_exp, in_tag, cyc, lat_en});
            if (out_valid) begin
                if (q.size() == 0) chk("spurious", 64'(out_valid), 64'(0));
                else begin
                    chk("data", out_data, q[0].d);
                    chk("tag", 64'(out_tag), 64'(q[0].t));
                    if (out_ready) begin
                        if (q[0].l) chk("latency", 64'(cyc - q[0].c), 64'(3));
                        void'(q.pop_front());
                    end
                end
            end
        end
    end

    task automatic send(input logic [63:0] d, input logic [6:0] sh, input logic r, a, w,
                        input logic [4:0] t, input logic [63:0] e);
        bit acc = 0;
        in_data = d; in_shamt = sh[5:0]; in_right = r; in_arith = a; in_word = w;
        in_tag = t; cur_exp = e; in_valid = 1'b1;
        for (int i = 0; i < 100 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
        end
        if (!acc) chk("send_timeout", 64'(0), 64'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_rnd(input logic [4:0] t);
        logic [63:0] d = {$urandom, $urandom};
        logic [6:0]  sh = 7'($urandom);
        logic r = 1'($urandom), a = 1'($urandom), w = 1'($urandom);
        send(d, sh, r, a, w, t, model(d, sh[5:0], r, a, w));
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
        chk("drain", 64'(q.size()), 64'(0));
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0; flush = 0; in_valid = 0; in_data = 0; in_shamt = 0; in_right = 0;
        in_arith = 0; in_word = 0; in_tag = 0; cur_exp = 0; out_ready = 1; lat_en = 1;
        repeat (2) @(posedge clk);
        #2 rst_n = 1;
        @(negedge clk);
        chk("rst_valid", 64'(out_valid), 64'(0));
        chk("rst_data", out_data, 64'(0));
        chk("rst_tag", 64'(out_tag), 64'(0));
        chk("rst_ready", 64'(in_ready), 64'(1));
        @(posedge clk); #1;

        // Directed vectors, unstalled, 3-cycle latency checked
        send(64'h8000_0000_0000_0000, 7'd63, 1, 0, 0, 5'd5, 64'h0000_0000_0000_0001);
        drain();
        send(64'h8000_0000_0000_0000, 7'd4,    1, 1, 0, 5'd1, 64'hF800_0000_0000_0000);
        send(64'h8000_0000_0000_0000, 7'h44,   1, 1, 0, 5'd2, 64'hF800_0000_0000_0000);
        send(64'h0000_0000_4000_0001, 7'd1,    0, 0, 1, 5'd3, 64'hFFFF_FFFF_8000_0002);
        send(64'h0000_0000_8000_0000, 7'd31,   1, 1, 1, 5'd4, 64'hFFFF_FFFF_FFFF_FFFF);
        send(64'hFFFF_FFFF_8000_0000, 7'd36,   1, 0, 1, 5'd6, 64'h0000_0000_0800_0000);
        send(64'h1234_5678_9ABC_DEF0, 7'd0,    0, 0, 0, 5'd7, 64'h1234_5678_9ABC_DEF0);
        send(64'h1234_5678_9ABC_DEF0, 7'd0,    1, 1, 1, 5'd8, 64'hFFFF_FFFF_9ABC_DEF0);
        send(64'h8000_0000_0000_0000, 7'd63,   1, 1, 0, 5'd9, 64'hFFFF_FFFF_FFFF_FFFF);
        send(64'h0000_0000_0000_0001, 7'd63,   0, 0, 0, 5'd10, 64'h8000_0000_0000_0000);
        drain();

        // Backpressure: out_ready low for cycles 0..6
        lat_en = 0; out_ready = 0;
        fork
            begin
                repeat (7) @(posedge clk);
                #1 out_ready = 1;
            end
            begin
                for (int i = 0; i < 3; i++) send_rnd(5'(i));
                #2 chk("bp_in_ready", 64'(in_ready), 64'(0));
                send_rnd(5'd3);
                send_rnd(5'd4);
            end
        join
        drain();

        // Random ops with random backpressure
        rnd_done = 0;
        fork
            begin
                for (int i = 0; i < 40; i++) send_rnd(5'($urandom));
                rnd_done = 1;
            end
            while (!rnd_done) begin
                @(posedge clk); #1;
                out_ready = 1'($urandom);
            end
        join
        out_ready = 1;
        drain();

        // Flush with three ops in flight
        lat_en = 1;
        send_rnd(5'd1); send_rnd(5'd2); send_rnd(5'd3);
        flush = 1; in_valid = 1; in_tag = 5'd7;
        @(negedge clk);
        chk("flush_out_valid", 64'(out_valid), 64'(0));
        chk("flush_in_ready", 64'(in_ready), 64'(0));
        @(posedge clk); #1;
        flush = 0; in_valid = 0; q.delete();
        @(negedge clk);
        chk("post_flush_valid", 64'(out_valid), 64'(0));
        chk("post_flush_ready", 64'(in_ready), 64'(1));
        @(posedge clk); #1;
        send(64'h0000_0000_0000_00F0, 7'd4, 1, 0, 0, 5'd9, 64'h0000_0000_0000_000F);
        drain();
        repeat (4) @(negedge clk);
        @(posedge clk); #1;

        // Asynchronous reset mid-stream with stalled results held
        lat_en = 0; out_ready = 0;
        send(64'h0123_4567_89AB_CDEF, 7'd0, 1, 0, 0, 5'd21, 64'h0123_4567_89AB_CDEF);
        send_rnd(5'd22); send_rnd(5'd23);
        @(posedge clk); #3;
        chk("pre_rst_valid", 64'(out_valid), 64'(1));
        rst_n = 0; q.delete();
        #1;
        chk("arst_valid", 64'(out_valid), 64'(0));
        chk("arst_data", out_data, 64'(0));
        chk("arst_tag", 64'(out_tag), 64'(0));
        @(posedge clk); #2;
        rst_n = 1; out_ready = 1;
        @(negedge clk);
        chk("rel_ready", 64'(in_ready), 64'(1));
        for (int i = 0; i < 5; i++) begin
            chk("no_stale", 64'(out_valid), 64'(0));
            @(negedge clk);
        end
        @(posedge clk); #1;
        lat_en = 1;
        send(64'h0000_0000_0000_0003, 7'd2, 0, 0, 0, 5'd30, 64'h0000_0000_0000_000C);
        drain();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/pipelined_shifter.md
Name: pipelined_shifter

Overview:
- Parametrised, pipelined barrel shifter for the RV64 ALU execute path.
- Supports SLL/SRL/SRA and the RV64 word variants (SLLW/SRLW/SRAW).
- Stages are split into pipeline registers with a valid/ready handshake, and a tag travels alongside each operation.
- Sits between issue and writeback so long shifts do not limit cycle time; throughput is 1 op/cycle.

Parameters:
- XLEN, 64: operand width; power of two, at least 8.
- LEVELS_PER_STAGE, 2: mux levels (of log2(XLEN)) per pipeline register; must be at least 1.
- TAG_W, 5: width of the passthrough tag (rd index).

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous kill of all in-flight ops
- in_valid  input  1  request valid
- in_ready  output  1  shifter can accept this cycle
- in_data  input  XLEN  operand rs1
- in_shamt  input  log2(XLEN)  shift amount (rs2/imm low bits)
- in_right  input  1  0 = left, 1 = right
- in_arith  input  1  arithmetic right shift (ignored when in_right=0)
- in_word  input  1  32-bit W variant (XLEN=64 only; tie 0 otherwise)
- in_tag  input  TAG_W  passthrough tag
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts
- out_data  output  XLEN  shifted result
- out_tag  output  TAG_W  tag of the result

Behaviour:
- Definitions:
  - L = log2(XLEN).
  - NSTAGES = ceil(L / LEVELS_PER_STAGE).
  - Latency from accept to out_valid is exactly NSTAGES cycles when there is no backpressure (XLEN=64, LEVELS=2 gives 3).
- Operand preparation (combinational, before stage 0):
  - Effective shamt = in_shamt[L-1:0], or in_shamt[4:0] when in_word.
  - In word mode, low 32 bits are sign-extended to XLEN if in_arith & in_right, otherwise zero-extended.
  - Left shifts bit-reverse the operand, shift right with fill 0, and bit-reverse the result. There is one right-shift datapath.
  - Fill bit = in_arith & in_right ? prepared operand MSB : 0.
- Shift levels:
  - Level k shifts by 2^k, ordered from the MSB level first: shamt[L-1] is applied first.
  - The fill bit and remaining shamt bits are registered with the data at each stage.
- Final fixup: when in_word, out_data = sign-extend of result[31:0] to XLEN, for all three word ops.
- Pipeline:
  - Each stage has a valid bit.
  - Stage i advances when !valid[i] or stage i+1 advances; the last stage advances on out_ready.
  - in_ready = stage 0 advance. This ready path is combinational through all stages by design.
  - Transfer occurs on in_valid & in_ready and on out_valid & out_ready.
  - Order is strictly preserved. No op is lost or duplicated under any ready pattern.
- Flush:
  - On the edge after flush=1, all valids are 0.
  - During a flush cycle, out_valid is forced to 0 and in_ready is forced to 0, so nothing is accepted or delivered.
- Reset:
  - rst_n low asynchronously clears all stage valids, data and tags to 0.
  - out_valid=0, out_data=0, out_tag=0, in_ready=1 after release.
  - Reset mid-operation discards all in-flight ops.
- Boundary values:
  - shamt=0 returns the operand unchanged, word-sign-extended in word mode.
  - shamt=XLEN-1 right arith gives all copies of the MSB.
  - Data/tag registers hold their value while stalled; out_data is stable while out_valid & !out_ready.

Decomposition:
- shifter_pkg holds:
  - direction/mode encoding constants;
  - a function computing NSTAGES from XLEN/LEVELS_PER_STAGE;
  - a bit-reverse function.
- Sub-module shift_stage (params XLEN, TAG_W, FIRST_LEVEL, NLEVELS):
  - applies NLEVELS mux levels;
  - owns its valid/data/fill/shamt/tag registers and advance logic.
- The top module generates NSTAGES instances; the last one may carry fewer levels.

Test Plan:
- SRL: 0x8000_0000_0000_0000, shamt 63 -> out_data 0x0000_0000_0000_0001, exactly 3 cycles after accept, tag echoed.
- SRA masking: 0x8000_0000_0000_0000, shamt 4 -> 0xF800_0000_0000_0000. Same again with shamt field 0x44 (masked to 4) -> same result.
- Word ops:
  - SLLW 0x0000_0000_4000_0001, shamt 1 -> 0xFFFF_FFFF_8000_0002.
  - SRAW 0x0000_0000_8000_0000, shamt 31 -> 0xFFFF_FFFF_FFFF_FFFF.
  - SRLW 0xFFFF_FFFF_8000_0000, shamt 36 (masked to 4) -> 0x0000_0000_0800_0000.
- Backpressure:
  - Stimulus: five back-to-back ops with tags 0..4; out_ready low for cycles 0..6, then high.
  - Required: in_ready falls after 3 accepts; remaining ops enter as slots free; results emerge tags 0..4 in order with out_data stable while stalled.
- Flush: 3 ops in flight, flush pulse for one cycle -> out_valid 0 next cycle. A new op with tag 9 after the flush emerges alone 3 cycles later.
- Reset: assert rst_n low mid-stream, asynchronously between clock edges -> out_valid/out_data/out_tag go 0 immediately. After release, in_ready=1 and no stale results appear.
